// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game engine.
//   game_state_e : top-level game FSM encoding
//   NUM_PIPES    : number of scrolling pipes
//   SCREEN_W/H   : visible screen size in pixels
//   FLOOR_Y      : bird bottom at or below this row is a floor collision
//   bcd_inc      : 2-digit BCD increment, saturating at 99
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } game_state_e;

  localparam int unsigned NUM_PIPES = 4;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned FLOOR_Y   = 475;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running on every clock.
//   Clk     : clock
//   Reset_n : asynchronous active-low reset, loads SEED
//   q       : current LFSR state (never all-zero for a non-zero SEED)
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q <= SEED;
    end else begin
      r_q <= {r_q[14:0], w_fb};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_controller.sv
// Game-state engine feeding the colour mapper. Once per frame tick it scrolls the pipes
// left, respawns pipes at the right with a pseudo-random gap, keeps a BCD score and
// detects bird/pipe/floor collisions.
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   frame_clk           : vsync pulse, asynchronous to Clk
//   game_start          : level, starts a game from IDLE or restarts from DEAD
//   BirdX/BirdY         : bird centre; Bird_size : bird half size
//   pipeX               : pipe centres; pipeGapLocation : gap centres
//   pipeWidth/GapSize   : constant half width / half gap
//   score               : BCD score; collision : in DEAD; running : in RUN
module pipe_controller
  import flappy_pkg::*;
#(
  parameter int unsigned SPEED       = 2,
  parameter int unsigned SPACING     = 160,
  parameter int unsigned START_X     = 640,
  parameter int unsigned PIPE_HALF_W = 24,
  parameter int unsigned GAP_HALF    = 50,
  parameter int unsigned GAP_MIN     = 112,
  parameter int unsigned FLOOR_LIM   = FLOOR_Y
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_clk,
  input  logic                           game_start,
  input  logic [9:0]                     BirdX,
  input  logic [9:0]                     BirdY,
  input  logic [9:0]                     Bird_size,
  output logic [NUM_PIPES-1:0][12:0]     pipeX,
  output logic [NUM_PIPES-1:0][12:0]     pipeWidth,
  output logic [NUM_PIPES-1:0][12:0]     pipeGapSize,
  output logic [NUM_PIPES-1:0][12:0]     pipeGapLocation,
  output logic [7:0]                     score,
  output logic                           collision,
  output logic                           running
);

  localparam logic [12:0] SPEED_W    = 13'(SPEED);
  localparam logic [12:0] HALF_W_W   = 13'(PIPE_HALF_W);
  localparam logic [12:0] GAP_HALF_W = 13'(GAP_HALF);
  localparam logic [12:0] GAP_MIN_W  = 13'(GAP_MIN);
  localparam logic [12:0] WRAP_W     = 13'(NUM_PIPES * SPACING);
  localparam logic [12:0] FLOOR_W    = 13'(FLOOR_LIM);
  localparam logic [12:0] INIT_GAP_W = 13'(SCREEN_H / 2);

  function automatic logic [12:0] init_x(input int unsigned idx);
    return 13'(START_X + idx * SPACING);
  endfunction

  // Frame tick: 2-flop synchroniser plus edge-detect flop. All reset to 1 so a frame_clk
  // that is already high when reset releases does not produce a spurious tick.
  logic r_sync1, r_sync2, r_sync3;
  logic w_tick;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_tick = r_sync2 & ~r_sync3;

  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;

  lfsr16 #(
    .SEED(16'hACE1)
  ) u_lfsr (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .q      (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:8];

  game_state_e                   r_state, w_state_nxt;
  logic [NUM_PIPES-1:0][12:0]    r_pipe_x, w_pipe_x_nxt;
  logic [NUM_PIPES-1:0][12:0]    r_gap, w_gap_nxt;
  logic [7:0]                    r_score, w_score_nxt;

  // Bird extents in 13 bits; the top edge clamps at 0 instead of wrapping.
  logic [12:0]                   w_bx, w_by, w_bs;
  logic [12:0]                   w_bird_top, w_bird_bot;
  logic [NUM_PIPES-1:0][12:0]    w_dx;
  logic                          w_hit;

  assign w_bx       = {3'b000, BirdX};
  assign w_by       = {3'b000, BirdY};
  assign w_bs       = {3'b000, Bird_size};
  assign w_bird_top = (BirdY >= Bird_size) ? (w_by - w_bs) : 13'd0;
  assign w_bird_bot = w_by + w_bs;

  always_comb begin
    w_hit = (w_bird_bot >= FLOOR_W);
    for (int i = 0; i < NUM_PIPES; i++) begin
      w_dx[i] = (r_pipe_x[i] >= w_bx) ? (r_pipe_x[i] - w_bx) : (w_bx - r_pipe_x[i]);
      if ((w_dx[i] < HALF_W_W + w_bs) &&
          ((w_bird_top < r_gap[i] - GAP_HALF_W) || (w_bird_bot > r_gap[i] + GAP_HALF_W))) begin
        w_hit = 1'b1;
      end
    end
  end

  // Candidate positions after one scroll step, and which pipes trail past the bird.
  logic [NUM_PIPES-1:0][12:0]    w_moved;
  logic [NUM_PIPES-1:0]          w_wrap;
  logic [NUM_PIPES-1:0]          w_pass;

  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      w_wrap[i]  = (r_pipe_x[i] <= SPEED_W);
      // Wrapping adds the full ring length so the spacing between pipes is preserved.
      w_moved[i] = w_wrap[i] ? (r_pipe_x[i] - SPEED_W + WRAP_W) : (r_pipe_x[i] - SPEED_W);
      w_pass[i]  = (r_pipe_x[i] + HALF_W_W >= w_bx) && (w_moved[i] + HALF_W_W < w_bx);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pipe_x_nxt = r_pipe_x;
    w_gap_nxt    = r_gap;
    w_score_nxt  = r_score;
    unique case (r_state)
      IDLE: begin
        if (game_start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_tick) begin
          if (w_hit) begin
            // A hit freezes the playfield, even if a pipe would also have scored.
            w_state_nxt = DEAD;
          end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
              w_pipe_x_nxt[i] = w_moved[i];
              if (w_wrap[i]) begin
                w_gap_nxt[i] = GAP_MIN_W + {5'b00000, w_lfsr[7:0]};
              end
            end
            if (|w_pass) begin
              w_score_nxt = bcd_inc(r_score);
            end
          end
        end
      end
      DEAD: begin
        if (game_start) begin
          w_state_nxt = RUN;
          for (int i = 0; i < NUM_PIPES; i++) begin
            w_pipe_x_nxt[i] = init_x(i);
            w_gap_nxt[i]    = INIT_GAP_W;
          end
          w_score_nxt = 8'h00;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_pipe_x[i] <= init_x(i);
        r_gap[i]    <= INIT_GAP_W;
      end
      r_score <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_pipe_x <= w_pipe_x_nxt;
      r_gap    <= w_gap_nxt;
      r_score  <= w_score_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipeWidth[i]   = HALF_W_W;
      pipeGapSize[i] = GAP_HALF_W;
    end
  end

  assign pipeX           = r_pipe_x;
  assign pipeGapLocation = r_gap;
  assign score           = r_score;
  assign collision       = (r_state == DEAD);
  assign running         = (r_state == RUN);

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: a behavioural game model predicts the state after
// each frame tick; predictions are queued when the frame edge is driven and compared when
// the DUT updates.
module tb_pipe_controller;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_clk;
  logic              game_start;
  logic [9:0]        BirdX, BirdY, Bird_size;
  logic [3:0][12:0]  pipeX, pipeWidth, pipeGapSize, pipeGapLocation;
  logic [7:0]        score;
  logic              collision, running;

  pipe_controller dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .game_start     (game_start),
    .BirdX          (BirdX),
    .BirdY          (BirdY),
    .Bird_size      (Bird_size),
    .pipeX          (pipeX),
    .pipeWidth      (pipeWidth),
    .pipeGapSize    (pipeGapSize),
    .pipeGapLocation(pipeGapLocation),
    .score          (score),
    .collision      (collision),
    .running        (running)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1, steps every clock.
  logic [15:0] m_lfsr;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct packed {
    logic [51:0] x;
    logic [51:0] gap;
    logic [7:0]  score;
    logic        coll;
    logic        run;
  } exp_t;

  exp_t sb[$];

  int         n_cmp = 0;
  int         n_err = 0;
  int         m_x[4];
  int         m_gap[4];
  logic [7:0] m_score;
  int         m_state;    // 0 idle, 1 run, 2 dead
  int         m_passes;
  bit         m_resp0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [51:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {13'(a3), 13'(a2), 13'(a1), 13'(a0)};
  endfunction

  function automatic logic [7:0] ref_bcd(input logic [7:0] v);
    if (v == 8'h99)          return v;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return v + 8'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_x[i]   = 640 + 160 * i;
      m_gap[i] = 240;
    end
    m_score = 8'h00;
    m_state = 0;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.x     = pack4(m_x[0], m_x[1], m_x[2], m_x[3]);
    e.gap   = pack4(m_gap[0], m_gap[1], m_gap[2], m_gap[3]);
    e.score = m_score;
    e.coll  = (m_state == 2);
    e.run   = (m_state == 1);
    return e;
  endfunction

  task automatic model_tick(input logic [15:0] l);
    int  bx, by, bs, ylo, dx, nx;
    bit  hit, pass;
    m_resp0 = 0;
    if (m_state != 1) return;
    bx  = int'(BirdX);
    by  = int'(BirdY);
    bs  = int'(Bird_size);
    ylo = (by >= bs) ? by - bs : 0;
    hit = (by + bs >= 475);
    for (int i = 0; i < 4; i++) begin
      dx = (bx > m_x[i]) ? bx - m_x[i] : m_x[i] - bx;
      if (dx < 24 + bs && (ylo < m_gap[i] - 50 || by + bs > m_gap[i] + 50)) hit = 1;
    end
    if (hit) begin
      m_state = 2;
      return;
    end
    pass = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_x[i] > 2) begin
        nx = m_x[i] - 2;
      end else begin
        nx       = (m_x[i] - 2 + 640) & 13'h1fff;
        m_gap[i] = 112 + int'(l[7:0]);
        if (i == 0) m_resp0 = 1;
      end
      if (m_x[i] + 24 >= bx && nx + 24 < bx) pass = 1;
      m_x[i] = nx;
    end
    if (pass) begin
      m_score = ref_bcd(m_score);
      m_passes++;
    end
  endtask

  // One frame_clk pulse; the DUT must hold its outputs until the 3rd Clk edge after it.
  task automatic do_tick();
    exp_t       e;
    logic [7:0] prev_score;
    string      stag;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk);
    check("lat_hold", 64'(pipeX), 64'(pack4(m_x[0], m_x[1], m_x[2], m_x[3])));
    prev_score = m_score;
    model_tick(m_lfsr);
    sb.push_back(model_exp());
    @(negedge Clk);
    e = sb.pop_front();
    if (prev_score == 8'h09)      stag = "score_09_10";
    else if (prev_score == 8'h99) stag = "score_99_sat";
    else if (prev_score == 8'h00) stag = "score_00";
    else                          stag = "score";
    check("pipeX", 64'(pipeX), 64'(e.x));
    check("gapLoc", 64'(pipeGapLocation), 64'(e.gap));
    check(stag, 64'(score), 64'(e.score));
    check("collision", 64'(collision), 64'(e.coll));
    check("running", 64'(running), 64'(e.run));
    if (m_resp0) begin
      check("gap_range", 64'(pipeGapLocation[0] >= 13'd112 && pipeGapLocation[0] <= 13'd367),
            64'd1);
    end
  endtask

  // Keep the zero-size bird inside the gap of whichever pipe is nearest to it.
  task automatic steer();
    int best, bd, d;
    best = 0;
    bd   = 1 << 20;
    for (int i = 0; i < 4; i++) begin
      d = (m_x[i] > 100) ? m_x[i] - 100 : 100 - m_x[i];
      if (d < bd) begin
        bd   = d;
        best = i;
      end
    end
    BirdY = 10'(m_gap[best]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pipeX"}, 64'(pipeX), 64'(pack4(640, 800, 960, 1120)));
    check({tag, "_gap"}, 64'(pipeGapLocation), 64'(pack4(240, 240, 240, 240)));
    check({tag, "_score"}, 64'(score), 64'd0);
    check({tag, "_coll"}, 64'(collision), 64'd0);
    check({tag, "_run"}, 64'(running), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n    = 1'b0;
    frame_clk  = 1'b0;
    game_start = 1'b0;
    BirdX      = 10'd100;
    BirdY      = 10'd240;
    Bird_size  = 10'd0;
    m_passes   = 0;
    m_resp0    = 0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_outputs("rst");
    check("width", 64'(pipeWidth), 64'(pack4(24, 24, 24, 24)));
    check("gapsize", 64'(pipeGapSize), 64'(pack4(50, 50, 50, 50)));
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    // Ticks in IDLE are ignored.
    do_tick();

    game_start = 1'b1;
    @(negedge Clk) game_start = 1'b0;
    m_state = 1;
    check("start_run", 64'(running), 64'd1);

    // Play until 100 pipes have passed: covers 00->01, 09->10, 99 saturation and respawns.
    for (int t = 0; t < 9000 && m_passes < 100; t++) begin
      do_tick();
      steer();
    end
    check("passes", 64'(m_passes), 64'd100);

    // Floor collision: next tick goes DEAD and the playfield freezes.
    BirdY     = 10'd470;
    Bird_size = 10'd8;
    do_tick();
    do_tick();

    // Restart from DEAD reinitialises layout and score on the same cycle.
    BirdY     = 10'd240;
    Bird_size = 10'd0;
    @(negedge Clk) game_start = 1'b1;
    @(negedge Clk);
    model_reset();
    m_state = 1;
    check("restart_pipeX", 64'(pipeX), 64'(pack4(640, 800, 960, 1120)));
    check("restart_gap", 64'(pipeGapLocation), 64'(pack4(240, 240, 240, 240)));
    check("restart_score", 64'(score), 64'd0);
    check("restart_run", 64'(running), 64'd1);
    check("restart_coll", 64'(collision), 64'd0);
    // game_start still high while running: must be ignored.
    do_tick();
    game_start = 1'b0;
    do_tick();

    // Asynchronous reset mid-RUN.
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("async_rst");
    @(negedge Clk) Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    do_tick();
    check("idle_after_rst", 64'(running), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
